// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory interface. Takes one load
//               or store per request from the execute stage and sequences
//               single-cycle mem_read / mem_write pulses towards an
//               edge-sensitive 64-bit-wide data memory. Partial stores are
//               done as read-modify-write; loads extract the addressed lanes
//               with sign or zero extension.
//
// Ports       : clk, rst_n            clock, asynchronous active-low reset
//               req / req_ready       request handshake (transfer on both)
//               req_write, req_size,  store flag, size (0=B,1=H,2=W,3=D),
//               req_signed            sign-extend flag for loads
//               req_addr, req_data    byte address, right-aligned store data
//               resp_valid/resp_ready response handshake
//               resp_data, resp_error load result / misaligned-or-range flag
//               address, write_data   memory doubleword index and data
//               mem_read, mem_write   memory strobes (one-cycle pulses)
//               read_data             memory read data
//
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int DEPTH_LOG2  = 5,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_error,
    output logic [63:0] address,
    output logic [63:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] read_data
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_rd   = 3'd1;
    localparam logic [2:0] c_rdw  = 3'd2;
    localparam logic [2:0] c_wr   = 3'd3;
    localparam logic [2:0] c_wre  = 3'd4;
    localparam logic [2:0] c_resp = 3'd5;

    logic [2:0]  r_state;
    logic        r_req_ready;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [63:0] r_address;
    logic [63:0] r_write_data;
    logic        r_resp_valid;
    logic [63:0] r_resp_data;
    logic        r_resp_error;

    // Request fields captured at accept
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [2:0]  r_off;
    logic [63:0] r_data;

    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_error;
    logic [63:0] w_index;
    logic [5:0]  w_shift;
    logic [63:0] w_lane_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load;
    logic [63:0] w_merged;

    // ------------------------------------------------------------------
    // Accept-time error detection
    // ------------------------------------------------------------------
    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = req_addr[0];
            2'd2:    w_misaligned = |req_addr[1:0];
            default: w_misaligned = |req_addr[2:0];
        endcase
    end

    generate
        if (CHECK_RANGE) begin : g_range_check
            assign w_out_of_range = |req_addr[63:DEPTH_LOG2+3];
        end else begin : g_no_range_check
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_error = w_misaligned | w_out_of_range;
    assign w_index = {{(64-DEPTH_LOG2){1'b0}}, req_addr[DEPTH_LOG2+2:3]};

    // ------------------------------------------------------------------
    // Lane handling. read_data is stable throughout the RDW cycle, so the
    // load result and the merged store word are formed directly from it
    // and captured into the response / write-data registers at the end of
    // RDW; those registers act as the read buffer.
    // ------------------------------------------------------------------
    assign w_shift = {r_off, 3'b000};

    always_comb begin
        w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (r_size)
            2'd0:    w_lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    w_lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    w_lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign w_shifted = read_data >> w_shift;
    assign w_merged  = (read_data & ~(w_lane_mask << w_shift)) |
                       ((r_data & w_lane_mask) << w_shift);

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'd0: w_load = r_signed ? {{56{w_shifted[7]}},  w_shifted[7:0]}
                                    : {56'd0, w_shifted[7:0]};
            2'd1: w_load = r_signed ? {{48{w_shifted[15]}}, w_shifted[15:0]}
                                    : {48'd0, w_shifted[15:0]};
            2'd2: w_load = r_signed ? {{32{w_shifted[31]}}, w_shifted[31:0]}
                                    : {32'd0, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer. Every output is a flop; strobes are set on entry to the
    // strobe state and cleared on exit, so each is a one-cycle pulse and
    // is always followed by a non-strobe state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_req_ready  <= 1'b1;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_address    <= 64'd0;
            r_write_data <= 64'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 64'd0;
            r_resp_error <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_off        <= 3'd0;
            r_data       <= 64'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (req) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_off       <= req_addr[2:0];
                        r_data      <= req_data;
                        r_address   <= w_index;
                        r_req_ready <= 1'b0;
                        if (w_error) begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_data  <= 64'd0;
                            r_state      <= c_resp;
                        end else if (req_write && (req_size == 2'd3)) begin
                            // Full doubleword store needs no read
                            r_write_data <= req_data;
                            r_mem_write  <= 1'b1;
                            r_state      <= c_wr;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= c_rd;
                        end
                    end
                end
                c_rd: begin
                    r_mem_read <= 1'b0;
                    r_state    <= c_rdw;
                end
                c_rdw: begin
                    if (r_write) begin
                        r_write_data <= w_merged;
                        r_mem_write  <= 1'b1;
                        r_state      <= c_wr;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_load;
                        r_resp_error <= 1'b0;
                        r_state      <= c_resp;
                    end
                end
                c_wr: begin
                    r_mem_write <= 1'b0;
                    r_state     <= c_wre;
                end
                c_wre: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= 64'd0;
                    r_resp_error <= 1'b0;
                    r_state      <= c_resp;
                end
                c_resp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= c_idle;
                    end
                end
                default: begin
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= c_idle;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign address    = r_address;
    assign write_data = r_write_data;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_error = r_resp_error;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Holds a 32 x 64-bit
//               data memory model preset to 0x5 per entry, applies a table
//               of directed requests with hand-computed expectations, and
//               runs hand-written sequences for response back-pressure and
//               reset in the middle of a read.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_data = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        resp_error;
    logic [63:0] address;
    logic [63:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] read_data = 64'd0;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.DEPTH_LOG2(5), .CHECK_RANGE(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    // Memory model: acts on strobes in the middle of the strobe cycle
    logic [63:0] mem [0:31];
    always @(negedge clk) begin
        if (mem_write) mem[address[4:0]] <= write_data;
        if (mem_read)  read_data <= mem[address[4:0]];
    end

    // Strobe rule monitor: never both, never two consecutive strobe cycles
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe <= 1'b0;
        end else begin
            if (mem_read || mem_write) begin
                n_checks++;
                if ((mem_read && mem_write) || prev_strobe) begin
                    n_fail++;
                    $display("FAIL strobe_rule @%0t: rd=%0b wr=%0b prev=%0b required isolated single strobe",
                             $time, mem_read, mem_write, prev_strobe);
                end
            end
            prev_strobe <= mem_read || mem_write;
        end
    end

    // Per-cycle observations after an accept (index = cycles after N)
    logic        o_rd   [0:15];
    logic        o_wr   [0:15];
    logic        o_rv   [0:15];
    logic        o_rdy  [0:15];
    logic        o_err  [0:15];
    logic [63:0] o_addr [0:15];
    logic [63:0] o_wd   [0:15];
    logic [63:0] o_rdat [0:15];

    typedef struct {
        bit          wr;
        bit [1:0]    size;
        bit          sgn;
        logic [63:0] addr;
        logic [63:0] data;
        int          exp_rd;    // cycle of read pulse, 0 = none
        int          exp_wr;    // cycle of write pulse, 0 = none
        int          exp_resp;  // first resp_valid cycle
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [0:21];

    function automatic vec_t mk(bit wr, bit [1:0] size, bit sgn, logic [63:0] addr,
                                logic [63:0] data, int erd, int ewr, int ersp,
                                logic [63:0] eaddr, logic [63:0] ewd,
                                logic [63:0] erdat, bit eerr);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.data = data;
        v.exp_rd = erd; v.exp_wr = ewr; v.exp_resp = ersp; v.exp_addr = eaddr;
        v.exp_wdata = ewd; v.exp_rdata = erdat; v.exp_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    task automatic capture(input int k);
        o_rd[k]   = mem_read;
        o_wr[k]   = mem_write;
        o_rv[k]   = resp_valid;
        o_rdy[k]  = req_ready;
        o_err[k]  = resp_error;
        o_addr[k] = address;
        o_wd[k]   = write_data;
        o_rdat[k] = resp_data;
    endtask

    // Called just after the accept edge; samples each cycle at its negedge
    task automatic run_window(input int ncyc);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            capture(k);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk({name, "_idle"}, 64'(req_ready), 64'd1);
    endtask

    task automatic drive_req(input bit wr, input bit [1:0] size, input bit sgn,
                             input logic [63:0] addr, input logic [63:0] data);
        req = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_data = data;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int frd, fwr, frv, nrd, nwr, nrv;
        wait_idle(tag);
        @(posedge clk);
        #1;
        drive_req(v.wr, v.size, v.sgn, v.addr, v.data);
        @(posedge clk);           // accept edge (end of cycle N)
        #1;
        req = 1'b0;
        run_window(7);
        frd = 0; fwr = 0; frv = 0; nrd = 0; nwr = 0; nrv = 0;
        for (int k = 7; k >= 1; k--) begin
            if (o_rd[k]) begin frd = k; nrd++; end
            if (o_wr[k]) begin fwr = k; nwr++; end
            if (o_rv[k]) begin frv = k; nrv++; end
        end
        chk({tag, "_ready_low"}, 64'(o_rdy[1]), 64'd0);
        chk({tag, "_rd_cycle"},  64'(frd), 64'(v.exp_rd));
        chk({tag, "_rd_pulses"}, 64'(nrd), (v.exp_rd != 0) ? 64'd1 : 64'd0);
        chk({tag, "_wr_cycle"},  64'(fwr), 64'(v.exp_wr));
        chk({tag, "_wr_pulses"}, 64'(nwr), (v.exp_wr != 0) ? 64'd1 : 64'd0);
        if (v.exp_wr != 0) begin
            chk({tag, "_wdata"},      o_wd[v.exp_wr],     v.exp_wdata);
            chk({tag, "_wdata_hold"}, o_wd[v.exp_wr + 1], v.exp_wdata);
        end
        chk({tag, "_resp_cycle"}, 64'(frv), 64'(v.exp_resp));
        chk({tag, "_resp_len"},   64'(nrv), 64'd1);
        chk({tag, "_resp_data"},  o_rdat[v.exp_resp], v.exp_rdata);
        chk({tag, "_resp_err"},   64'(o_err[v.exp_resp]), 64'(v.exp_err));
        chk({tag, "_address"},    o_addr[v.exp_resp], v.exp_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrv, nrd;
        for (int i = 0; i < 32; i++) mem[i] = 64'h5;

        //           wr sz sg addr                   data                   rd wr rsp addr  wdata                  rdata                  err
        vecs[0]  = mk(0, 3, 0, 64'h10,               64'h0,                 1, 0, 3, 64'd2,  64'h0,                 64'h5,                 0);
        vecs[1]  = mk(1, 0, 0, 64'h09,               64'hAB,                1, 3, 5, 64'd1,  64'h0000_0000_0000_AB05, 64'h0,               0);
        vecs[2]  = mk(0, 0, 1, 64'h09,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'hFFFF_FFFF_FFFF_FFAB, 0);
        vecs[3]  = mk(0, 0, 0, 64'h09,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'h0000_0000_0000_00AB, 0);
        vecs[4]  = mk(0, 1, 1, 64'h08,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'hFFFF_FFFF_FFFF_AB05, 0);
        vecs[5]  = mk(0, 1, 0, 64'h03,               64'h0,                 0, 0, 1, 64'd0,  64'h0, 64'h0,                 1);
        vecs[6]  = mk(0, 3, 0, 64'h100,              64'h0,                 0, 0, 1, 64'd0,  64'h0, 64'h0,                 1);
        vecs[7]  = mk(1, 2, 0, 64'h24,  64'hDEAD_BEEF_89AB_CDEF,            1, 3, 5, 64'd4,  64'h89AB_CDEF_0000_0005, 64'h0,       0);
        vecs[8]  = mk(0, 2, 1, 64'h24,               64'h0,                 1, 0, 3, 64'd4,  64'h0, 64'hFFFF_FFFF_89AB_CDEF, 0);
        vecs[9]  = mk(0, 2, 0, 64'h24,               64'h0,                 1, 0, 3, 64'd4,  64'h0, 64'h0000_0000_89AB_CDEF, 0);
        vecs[10] = mk(1, 1, 0, 64'h0E,  64'h1234_5678_9ABC_7F80,            1, 3, 5, 64'd1,  64'h7F80_0000_0000_AB05, 64'h0,       0);
        vecs[11] = mk(0, 1, 1, 64'h0E,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'h0000_0000_0000_7F80, 0);
        vecs[12] = mk(0, 0, 1, 64'h0E,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);
        vecs[13] = mk(0, 3, 1, 64'h08,               64'h0,                 1, 0, 3, 64'd1,  64'h0, 64'h7F80_0000_0000_AB05, 0);
        vecs[14] = mk(1, 2, 0, 64'h22,               64'h1,                 0, 0, 1, 64'd4,  64'h0, 64'h0,                 1);
        vecs[15] = mk(0, 3, 0, 64'h0C,               64'h0,                 0, 0, 1, 64'd1,  64'h0, 64'h0,                 1);
        vecs[16] = mk(0, 3, 0, 64'hF8,               64'h0,                 1, 0, 3, 64'd31, 64'h0, 64'h5,                 0);
        vecs[17] = mk(1, 0, 0, 64'hFF,               64'hC3,                1, 3, 5, 64'd31, 64'hC300_0000_0000_0005, 64'h0,       0);
        vecs[18] = mk(0, 0, 0, 64'hFF,               64'h0,                 1, 0, 3, 64'd31, 64'h0, 64'h0000_0000_0000_00C3, 0);
        vecs[19] = mk(0, 3, 0, 64'h8000_0000_0000_0000, 64'h0,              0, 0, 1, 64'd0,  64'h0, 64'h0,                 1);
        vecs[20] = mk(0, 2, 0, 64'h24,               64'h0,                 1, 0, 3, 64'd4,  64'h0, 64'h0000_0000_89AB_CDEF, 0);
        vecs[21] = mk(1, 3, 0, 64'h28,  64'hA5A5_A5A5_A5A5_A5A5,            0, 1, 3, 64'd5,  64'hA5A5_A5A5_A5A5_A5A5, 64'h0,       0);

        // Reset values
        #12;
        chk("rst_mem_read",   64'(mem_read),   64'd0);
        chk("rst_mem_write",  64'(mem_write),  64'd0);
        chk("rst_address",    address,         64'd0);
        chk("rst_write_data", write_data,      64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data",  resp_data,       64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 22; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Full store with response back-pressure and an ignored request
        wait_idle("bp");
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        drive_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122_3344_5566_7788);
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            capture(k);
            @(posedge clk);
            #1;
            if (k == 3) drive_req(1'b0, 2'd3, 1'b0, 64'h08, 64'h0);
            if (k == 4) req = 1'b0;
            if (k == 5) resp_ready = 1'b1;
        end
        nrv = 0; nrd = 0;
        for (int k = 1; k <= 9; k++) begin
            if (o_rv[k]) nrv++;
            if (o_rd[k]) nrd++;
        end
        chk("bp_wr_at_1",     64'(o_wr[1]),  64'd1);
        chk("bp_wdata",       o_wd[1],       64'h1122_3344_5566_7788);
        chk("bp_address",     o_addr[1],     64'd3);
        chk("bp_no_read",     64'(nrd),      64'd0);
        chk("bp_resp_first",  64'(o_rv[3] && !o_rv[2]), 64'd1);
        chk("bp_resp_len",    64'(nrv),      64'd4);
        chk("bp_resp_end",    64'(o_rv[6] && !o_rv[7]), 64'd1);
        chk("bp_resp_data",   o_rdat[6],     64'd0);
        chk("bp_resp_err",    64'(o_err[6]), 64'd0);
        chk("bp_ready_hold",  64'(o_rdy[4] || o_rdy[5] || o_rdy[6]), 64'd0);
        chk("bp_ready_back",  64'(o_rdy[7] && o_rdy[8]), 64'd1);
        apply_vec(mk(0, 3, 0, 64'h18, 64'h0, 1, 0, 3, 64'd3, 64'h0, 64'h1122_3344_5566_7788, 0), "bp_readback");

        // Reset asserted during the RD cycle of a load
        wait_idle("mrst");
        @(posedge clk);
        #1;
        drive_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        @(posedge clk);
        #1;
        req = 1'b0;
        #1;
        chk("mrst_rd_before", 64'(mem_read), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_dropped", 64'(mem_read),   64'd0);
        chk("mrst_no_resp",    64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(5);
        nrv = 0; nrd = 0;
        for (int k = 1; k <= 5; k++) begin
            if (o_rv[k]) nrv++;
            if (o_rd[k]) nrd++;
        end
        chk("mrst_resp_none",  64'(nrv), 64'd0);
        chk("mrst_read_none",  64'(nrd), 64'd0);
        chk("mrst_ready",      64'(o_rdy[1] && o_rdy[5]), 64'd1);
        apply_vec(mk(0, 3, 0, 64'h18, 64'h0, 1, 0, 3, 64'd3, 64'h0, 64'h1122_3344_5566_7788, 0), "mrst_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
